// File: rtl/gpio_irq_ctrl.sv
// APB-mapped GPIO interrupt controller: synchronized pad inputs, edge/level detection, W1C status.
// Define GPIO_IRQ_DEBOUNCE_EN to build in the per-bit 3-sample debounce filter and its prescaler.
module gpio_irq_ctrl (
   input  logic        apb_pclk,
   input  logic        apb_prst,
   input  logic        apb_psel,
   input  logic        apb_penable,
   input  logic        apb_pwrite,
   input  logic [31:0] apb_paddr,
   input  logic [31:0] apb_pwdata,
   output logic [31:0] apb_prdata,
   input  logic [31:0] gpio_i,
   output logic        irq
);

   localparam logic [7:0] ADDR_INT_EN   = 8'h60;
   localparam logic [7:0] ADDR_INT_TYPE = 8'h64;
   localparam logic [7:0] ADDR_INT_POL  = 8'h68;
   localparam logic [7:0] ADDR_INT_STAT = 8'h6C;
   localparam logic [7:0] ADDR_DB_CNT   = 8'h70;
   localparam logic [7:0] ADDR_IN_VAL   = 8'h74;

   logic        wr_stb;
   logic        rd_stb;
   logic [7:0]  offset;
   logic        unused_paddr;

   logic [31:0] int_en;
   logic [31:0] int_type;
   logic [31:0] int_pol;
   logic [31:0] int_stat;

   logic [31:0] s1;
   logic [31:0] s2;
   logic [31:0] f;
   logic [31:0] prev;

   logic [31:0] pol_match;
   logic [31:0] edge_hit;
   logic [31:0] set_vec;
   logic [31:0] w1c_vec;
   logic [31:0] db_cnt_rd;

   assign wr_stb       = apb_psel & apb_penable & apb_pwrite;
   assign rd_stb       = apb_psel & apb_penable & ~apb_pwrite;
   assign offset       = apb_paddr[7:0];
   assign unused_paddr = ^apb_paddr[31:8];

   // Two-flop synchronizer; prev lags the filtered value by one cycle for edge detection.
   always_ff @(posedge apb_pclk or posedge apb_prst) begin
      if (apb_prst) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
      end else begin
         // NOTE: every clocked assignment is non-blocking so s1 -> s2 -> prev shift, not collapse.
         s1   <= gpio_i;
         s2   <= s1;
         prev <= f;
      end
   end

`ifdef GPIO_IRQ_DEBOUNCE_EN
   logic [15:0] db_cnt;
   logic [15:0] presc;
   logic        tick;
   logic [31:0] hist0;
   logic [31:0] hist1;
   logic [31:0] hist2;
   logic [31:0] agree;

   assign tick  = (presc == db_cnt);
   assign agree = ~(hist0 ^ hist1) & ~(hist1 ^ hist2);

   // Shared prescaler: one sample tick every db_cnt+1 cycles, restarted by any DB_CNT write.
   always_ff @(posedge apb_pclk or posedge apb_prst) begin
      if (apb_prst) begin
         db_cnt <= '0;
         presc  <= '0;
         hist0  <= '0;
         hist1  <= '0;
         hist2  <= '0;
         f      <= '0;
      end else begin
         if (wr_stb && offset == ADDR_DB_CNT) begin
            db_cnt <= apb_pwdata[15:0];
            presc  <= '0;
         end else if (tick) begin
            presc  <= '0;
         end else begin
            presc  <= presc + 16'd1;
         end
         if (tick) begin
            hist0 <= s2;
            hist1 <= hist0;
            hist2 <= hist1;
         end
         // A bit only follows the pad once three consecutive samples agree.
         f <= (f & ~agree) | (hist0 & agree);
      end
   end

   assign db_cnt_rd = {16'h0000, db_cnt};
`else
   always_ff @(posedge apb_pclk or posedge apb_prst) begin
      if (apb_prst) begin
         f <= '0;
      end else begin
         f <= s2;
      end
   end

   assign db_cnt_rd = '0;
`endif

   assign pol_match = ~(f ^ int_pol);
   assign edge_hit  = (f ^ prev) & pol_match;
   assign set_vec   = (int_type & edge_hit) | (~int_type & pol_match);
   assign w1c_vec   = (wr_stb && offset == ADDR_INT_STAT) ? apb_pwdata : '0;

   // Set terms are OR-ed in after the W1C mask so a coincident set always wins.
   always_ff @(posedge apb_pclk or posedge apb_prst) begin
      if (apb_prst) begin
         int_en   <= '0;
         int_type <= '0;
         int_pol  <= '0;
         int_stat <= '0;
      end else begin
         if (wr_stb && offset == ADDR_INT_EN)   int_en   <= apb_pwdata;
         if (wr_stb && offset == ADDR_INT_TYPE) int_type <= apb_pwdata;
         if (wr_stb && offset == ADDR_INT_POL)  int_pol  <= apb_pwdata;
         int_stat <= (int_stat & ~w1c_vec) | set_vec;
      end
   end

   always_comb begin
      // NOTE: defaulting the output first keeps this block free of inferred latches.
      apb_prdata = '0;
      if (rd_stb) begin
         case (offset)
            ADDR_INT_EN:   apb_prdata = int_en;
            ADDR_INT_TYPE: apb_prdata = int_type;
            ADDR_INT_POL:  apb_prdata = int_pol;
            ADDR_INT_STAT: apb_prdata = int_stat;
            ADDR_DB_CNT:   apb_prdata = db_cnt_rd;
            ADDR_IN_VAL:   apb_prdata = f;
            default:       apb_prdata = '0;
         endcase
      end
   end

   assign irq = |(int_stat & int_en);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: register table, edge/level/W1C timing, reset abort, optional debounce.
module tb_gpio_irq_ctrl;

   logic        clk;
   logic        rst;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic [31:0] gpio;
   logic        irq;

`ifdef GPIO_IRQ_DEBOUNCE_EN
   localparam int STAT_LAT = 7;
`else
   localparam int STAT_LAT = 4;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   gpio_irq_ctrl dut (
      .apb_pclk    (clk),
      .apb_prst    (rst),
      .apb_psel    (psel),
      .apb_penable (penable),
      .apb_pwrite  (pwrite),
      .apb_paddr   (paddr),
      .apb_pwdata  (pwdata),
      .apb_prdata  (prdata),
      .gpio_i      (gpio),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Single zero-wait access phase; call at a falling edge, returns at the next one.
   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
      #1 d = prdata;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      apb_read(a, d);
      check(name, d, exp);
   endtask

   initial begin
      logic [31:0] d;
      int          lat;
      logic        seen;

      vecs[0]  = '{32'h60,  32'hA5A5_A5A5, 32'h60, 32'hA5A5_A5A5};
      vecs[1]  = '{32'h64,  32'h5A5A_5A5A, 32'h64, 32'h5A5A_5A5A};
      vecs[2]  = '{32'h68,  32'h1234_5678, 32'h68, 32'h1234_5678};
`ifdef GPIO_IRQ_DEBOUNCE_EN
      vecs[3]  = '{32'h70,  32'hDEAD_BEEF, 32'h70, 32'h0000_BEEF};
`else
      vecs[3]  = '{32'h70,  32'hDEAD_BEEF, 32'h70, 32'h0000_0000};
`endif
      vecs[4]  = '{32'h74,  32'hFFFF_FFFF, 32'h74, 32'h0000_0000};
      vecs[5]  = '{32'h7C,  32'hFFFF_FFFF, 32'h7C, 32'h0000_0000};
      vecs[6]  = '{32'h160, 32'h0000_F00D, 32'h60, 32'h0000_F00D};
      vecs[7]  = '{32'h61,  32'hFFFF_FFFF, 32'h60, 32'h0000_F00D};
      vecs[8]  = '{32'h80,  32'hFFFF_FFFF, 32'h80, 32'h0000_0000};
      vecs[9]  = '{32'h64,  32'h0000_0000, 32'h64, 32'h0000_0000};
      vecs[10] = '{32'h68,  32'h0000_0000, 32'h68, 32'h0000_0000};
      vecs[11] = '{32'h60,  32'h0000_0000, 32'h60, 32'h0000_0000};
      vecs[12] = '{32'h70,  32'h0000_0000, 32'h70, 32'h0000_0000};

      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; gpio = '0;
      repeat (3) @(negedge clk);

      // Everything reads zero while reset is held.
      for (int a = 'h60; a <= 'h74; a += 4) begin
         check_reg($sformatf("reset_reg_%02h", a), 32'(a), 32'h0);
         @(negedge clk);
      end
      check("reset_irq", {31'h0, irq}, 32'h0);

      rst = 1'b0;
      check_reg("release_stat", 32'h6C, 32'h0);
      @(negedge clk);
      // Default config is level-low on every bit and the pads are low.
      check_reg("level_low_all", 32'h6C, 32'hFFFF_FFFF);
      check("irq_masked", {31'h0, irq}, 32'h0);

      for (int i = 0; i < 13; i++) begin
         apb_write(vecs[i].waddr, vecs[i].wdata);
         check_reg($sformatf("vec%0d_rd_%02h", i, vecs[i].raddr[7:0]), vecs[i].raddr, vecs[i].exp);
      end
      check_reg("stat_latch_no_en", 32'h6C, 32'hFFFF_FFFF);
      check("irq_after_table", {31'h0, irq}, 32'h0);

      // Rising edge on bit 3: status and irq appear on the fourth edge after the pin change.
      apb_write(32'h64, 32'hFFFF_FFFF);
      apb_write(32'h68, 32'hFFFF_FFFF);
      apb_write(32'h6C, 32'hFFFF_FFFF);
      check_reg("edge_cfg_clear", 32'h6C, 32'h0);
      apb_write(32'h60, 32'h8);
      gpio[3] = 1'b1;
      repeat (STAT_LAT - 1) @(negedge clk);
      check_reg("edge3_not_yet", 32'h6C, 32'h0);
      check("edge3_irq_not_yet", {31'h0, irq}, 32'h0);
      @(negedge clk);
      check_reg("edge3_stat", 32'h6C, 32'h8);
      check("edge3_irq", {31'h0, irq}, 32'h1);
      apb_write(32'h6C, 32'h8);
      check("edge3_w1c_irq", {31'h0, irq}, 32'h0);
      check_reg("edge3_w1c_stat", 32'h6C, 32'h0);

      // Level-low on bit 0 re-sets straight through a W1C while the pin stays low.
      apb_write(32'h64, 32'hFFFF_FFFE);
      apb_write(32'h68, 32'hFFFF_FFFE);
      @(negedge clk);
      check_reg("lvl0_set", 32'h6C, 32'h1);
      check("lvl0_irq_masked", {31'h0, irq}, 32'h0);
      apb_write(32'h6C, 32'h1);
      check_reg("lvl0_w1c_persist", 32'h6C, 32'h1);
      gpio[0] = 1'b1;
      repeat (STAT_LAT) @(negedge clk);
      apb_write(32'h6C, 32'h1);
      check_reg("lvl0_w1c_clear", 32'h6C, 32'h0);
      repeat (2) @(negedge clk);
      check_reg("lvl0_stays_clear", 32'h6C, 32'h0);

      // Rising edge on bit 5 coinciding with a W1C of the same bit: set wins.
      gpio[5] = 1'b1;
      repeat (STAT_LAT - 1) @(negedge clk);
      apb_write(32'h6C, 32'h20);
      check_reg("edge5_set_wins", 32'h6C, 32'h20);

      // Reconfiguring polarity and type leaves latched status alone.
      apb_write(32'h68, 32'hFFFF_FFDE);
      @(negedge clk);
      check_reg("pol_change_keeps", 32'h6C, 32'h20);
      apb_write(32'h64, 32'hFFFF_FFFF);
      @(negedge clk);
      check_reg("type_change_keeps", 32'h6C, 32'h20);
      check_reg("in_val", 32'h74, 32'h29);

`ifdef GPIO_IRQ_DEBOUNCE_EN
      gpio = '0;
      apb_write(32'h68, 32'hFFFF_FFFF);
      repeat (10) @(negedge clk);
      apb_write(32'h6C, 32'hFFFF_FFFF);
      check_reg("db_cfg_clear", 32'h6C, 32'h0);

      // 15-cycle glitch with a tick every 10 cycles never fills the history.
      apb_write(32'h70, 32'h9);
      check_reg("db_cnt_rd", 32'h70, 32'h9);
      gpio[7] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 65; i++) begin
         if (i == 15) gpio[7] = 1'b0;
         @(negedge clk);
         apb_read(32'h74, d);
         if (d[7]) seen = 1'b1;
      end
      check("db_pulse_filtered", {31'h0, seen}, 32'h0);
      check_reg("db_pulse_no_stat", 32'h6C, 32'h0);

      // A held level propagates once three ticks agree.
      apb_write(32'h70, 32'h9);
      gpio[7] = 1'b1;
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         apb_read(32'h74, d);
         if (lat < 0 && d[7]) lat = i;
      end
      check_range("db_level_latency", lat, 30, 42);
      check_reg("db_level_stat", 32'h6C, 32'h80);
      gpio[7] = 1'b0;
      apb_write(32'h70, 32'h0);
`endif

      // Reset in the middle of activity clears everything at once.
      gpio = '0;
      apb_write(32'h68, 32'hFFFF_FF00);
      apb_write(32'h64, 32'hFFFF_FF00);
      apb_write(32'h6C, 32'hFFFF_FFFF);
      apb_write(32'h60, 32'hFF);
      repeat (STAT_LAT + 2) @(negedge clk);
      check_reg("pre_reset_stat", 32'h6C, 32'hFF);
      check("pre_reset_irq", {31'h0, irq}, 32'h1);
`ifdef GPIO_IRQ_DEBOUNCE_EN
      apb_write(32'h70, 32'h9);
`endif
      gpio[7] = 1'b1;
      repeat (12) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("mid_reset_irq", {31'h0, irq}, 32'h0);
      for (int a = 'h60; a <= 'h74; a += 4) begin
         check_reg($sformatf("mid_reset_reg_%02h", a), 32'(a), 32'h0);
      end
      @(negedge clk);
      gpio[7] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check_reg("post_reset_in_val", 32'h74, 32'h0);
      check("post_reset_irq", {31'h0, irq}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
